// File: rtl/alu4_resp_if.sv
// ---------------------------------------------------------------------------
// alu4_resp_if
//   Request/response bundle for the handshaked 4-bit ALU responder.
//   The request channel carries {req_a, req_b, req_opt} under req_valid/req_ready.
//   The response channel carries {rsp_y, rsp_carry, rsp_ovf, rsp_zero} under
//   rsp_valid/rsp_ready.
//   Modports:
//     master : requester side (drives requests, consumes responses)
//     slave  : responder side (alu4_resp)
// ---------------------------------------------------------------------------
interface alu4_resp_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [2:0] req_opt;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_y;
    logic       rsp_carry;
    logic       rsp_ovf;
    logic       rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_opt, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_carry, rsp_ovf, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_opt, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_carry, rsp_ovf, rsp_zero
    );
endinterface

// File: rtl/alu4_resp.sv
// ---------------------------------------------------------------------------
// alu4_resp
//   Handshaked 4-bit ALU responder. Each accepted request is evaluated and the
//   result plus flags are written into a small response FIFO, so a stalled
//   consumer never loses a result. There is no combinational path from the
//   request channel to the response channel: a result is visible at the
//   earliest one cycle after its request is accepted.
//
//   Parameters:
//     DEPTH  response FIFO entries (power of two, >= 2)
//     CNT_W  width of the accepted-request counter
//
//   Ports:
//     clk        clock, everything on the rising edge
//     rst_n      synchronous active-low reset
//     bus        alu4_resp_if.slave (request and response channels)
//     req_count  number of accepted requests, wraps modulo 2^CNT_W
//
//   Opcodes: 000 a+b, 001 a-b, 010 ~a, 011 a&b, 100 a|b, 101 a^b,
//            110 signed a<b, 111 a==b (compare results are 0001 / 0000).
//   carry/ovf are only meaningful for add/sub and read 0 otherwise.
// ---------------------------------------------------------------------------
module alu4_resp #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu4_resp_if.slave       bus,
    output logic [CNT_W-1:0] req_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    typedef struct packed {
        logic [3:0] y;
        logic       carry;
        logic       ovf;
        logic       zero;
    } rsp_t;

    // -----------------------------------------------------------------------
    // ALU
    // -----------------------------------------------------------------------
    logic [4:0] w_sum;
    logic [4:0] w_dif;
    logic       w_add_ovf;
    logic       w_sub_ovf;
    logic       w_lt;
    rsp_t       w_res;

    assign w_sum = {1'b0, bus.req_a} + {1'b0, bus.req_b};
    // Subtraction as a + ~b + 1 so bit 4 is the carry-out (i.e. NOT borrow).
    assign w_dif = {1'b0, bus.req_a} + {1'b0, ~bus.req_b} + 5'd1;

    assign w_add_ovf = (bus.req_a[3] == bus.req_b[3]) && (w_sum[3] != bus.req_a[3]);
    assign w_sub_ovf = (bus.req_a[3] != bus.req_b[3]) && (w_dif[3] != bus.req_a[3]);
    // The sign of a-b alone is wrong when the subtraction overflows; correcting
    // with the overflow bit gives the true signed less-than.
    assign w_lt = w_dif[3] ^ w_sub_ovf;

    // NOTE: every field gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_res = '0;
        unique case (bus.req_opt)
            3'b000: begin
                w_res.y     = w_sum[3:0];
                w_res.carry = w_sum[4];
                w_res.ovf   = w_add_ovf;
            end
            3'b001: begin
                w_res.y     = w_dif[3:0];
                w_res.carry = w_dif[4];
                w_res.ovf   = w_sub_ovf;
            end
            3'b010: w_res.y = ~bus.req_a;
            3'b011: w_res.y = bus.req_a & bus.req_b;
            3'b100: w_res.y = bus.req_a | bus.req_b;
            3'b101: w_res.y = bus.req_a ^ bus.req_b;
            3'b110: w_res.y = {3'b000, w_lt};
            3'b111: w_res.y = {3'b000, bus.req_a == bus.req_b};
        endcase
        w_res.zero = (w_res.y == 4'b0000);
    end

    // -----------------------------------------------------------------------
    // Response FIFO
    // -----------------------------------------------------------------------
    rsp_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic [CNT_W-1:0] r_req_count;

    logic w_valid;
    logic w_pop;
    logic w_ready;
    logic w_push;
    rsp_t w_head;

    assign w_valid = (r_occ != '0);
    assign w_pop   = w_valid & bus.rsp_ready;
    // A full FIFO can still accept when its head leaves on the same edge.
    // Gating with rst_n keeps a request offered during reset from being taken.
    assign w_ready = rst_n & ((r_occ < OCC_FULL) | w_pop);
    assign w_push  = bus.req_valid & w_ready;

    // NOTE: the storage array is deliberately left out of reset; the occupancy
    // counter alone decides what is valid, and the outputs below are forced to
    // zero while empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_res;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_req_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
                r_req_count <= r_req_count + CNT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign w_head = w_valid ? r_mem[r_rd_ptr] : '0;

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = w_valid;
    assign bus.rsp_y     = w_head.y;
    assign bus.rsp_carry = w_head.carry;
    assign bus.rsp_ovf   = w_head.ovf;
    assign bus.rsp_zero  = w_head.zero;
    assign req_count     = r_req_count;

endmodule

// File: tb/tb_alu4_resp.sv
// ---------------------------------------------------------------------------
// tb_alu4_resp
//   Self-checking bench for alu4_resp. A queue of expected responses, filled
//   from an arithmetic reference of the opcode table at every accept, is
//   compared against every popped response; handshake and counter outputs are
//   compared every cycle. Directed sections cover flag corner cases,
//   exhaustive signed compare, back-pressure, full push+pop, mid-stream reset
//   and counter wrap, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_alu4_resp;

    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    typedef struct {
        logic [3:0] y;
        logic       carry;
        logic       ovf;
        logic       zero;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [CNT_W-1:0] req_count;

    alu4_resp_if bus ();

    alu4_resp #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .req_count (req_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    int   exp_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: results straight from integer arithmetic.
    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        exp_t e;
        int ua, ub, sa, sb, r, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.y = 4'd0; e.carry = 1'b0; e.ovf = 1'b0;
        case (op)
            3'd0: begin
                r = ua + ub; s = sa + sb;
                e.y = 4'(r); e.carry = (r > 15); e.ovf = (s > 7) || (s < -8);
            end
            3'd1: begin
                r = ua - ub; s = sa - sb;
                e.y = 4'(r); e.carry = (ua >= ub); e.ovf = (s > 7) || (s < -8);
            end
            3'd2: e.y = ~a;
            3'd3: e.y = a & b;
            3'd4: e.y = a | b;
            3'd5: e.y = a ^ b;
            3'd6: e.y = (sa < sb) ? 4'd1 : 4'd0;
            default: e.y = (ua == ub) ? 4'd1 : 4'd0;
        endcase
        e.zero = (e.y == 4'd0);
        return e;
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        bus.req_a   = a;
        bus.req_b   = b;
        bus.req_opt = op;
    endtask

    // One clock: compare at the falling edge, update the model across the
    // rising edge, return 1 time unit after it.
    task automatic cycle();
        logic exp_pop;
        logic exp_ready;
        logic do_acc;
        exp_t head;
        @(negedge clk);
        exp_pop   = (sb_q.size() != 0) && bus.rsp_ready;
        exp_ready = rst_n && ((sb_q.size() < DEPTH) || exp_pop);
        check("rsp_valid", 32'(bus.rsp_valid), 32'(sb_q.size() != 0));
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("req_count", 32'(req_count), 32'(exp_count));
        if (exp_pop && rst_n) begin
            head = sb_q[0];
            check("rsp_y",     32'(bus.rsp_y),     32'(head.y));
            check("rsp_carry", 32'(bus.rsp_carry), 32'(head.carry));
            check("rsp_ovf",   32'(bus.rsp_ovf),   32'(head.ovf));
            check("rsp_zero",  32'(bus.rsp_zero),  32'(head.zero));
        end
        do_acc = rst_n && bus.req_valid && exp_ready;
        @(posedge clk);
        if (!rst_n) begin
            sb_q.delete();
            exp_count = 0;
        end else begin
            if (exp_pop) void'(sb_q.pop_front());
            if (do_acc) begin
                sb_q.push_back(model(bus.req_a, bus.req_b, bus.req_opt));
                exp_count = (exp_count + 1) % (1 << CNT_W);
            end
        end
        #1;
    endtask

    // Single request into an empty FIFO; result must appear one cycle later.
    task automatic flag_vec(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] op, input logic [3:0] ey, input logic ec,
                            input logic eo, input logic ez);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        drive(a, b, op);
        cycle();
        bus.req_valid = 1'b0;
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_y"},     32'(bus.rsp_y),     32'(ey));
        check({tag, "_carry"}, 32'(bus.rsp_carry), 32'(ec));
        check({tag, "_ovf"},   32'(bus.rsp_ovf),   32'(eo));
        check({tag, "_zero"},  32'(bus.rsp_zero),  32'(ez));
        cycle();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        drive(4'd0, 4'd0, 3'd0);

        // Reset state
        @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_count", 32'(req_count),     32'd0);
        check("rst_y",     32'(bus.rsp_y),     32'd0);
        check("rst_flags", 32'({bus.rsp_carry, bus.rsp_ovf, bus.rsp_zero}), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Flag corner cases
        flag_vec("add_7_1", 4'h7, 4'h1, 3'b000, 4'h8, 1'b0, 1'b1, 1'b0);
        flag_vec("add_f_1", 4'hF, 4'h1, 3'b000, 4'h0, 1'b1, 1'b0, 1'b1);
        flag_vec("sub_8_1", 4'h8, 4'h1, 3'b001, 4'h7, 1'b1, 1'b1, 1'b0);
        flag_vec("sub_0_1", 4'h0, 4'h1, 3'b001, 4'hF, 1'b0, 1'b0, 1'b0);
        flag_vec("lt_8_7",  4'h8, 4'h7, 3'b110, 4'h1, 1'b0, 1'b0, 1'b0);
        flag_vec("lt_7_8",  4'h7, 4'h8, 3'b110, 4'h0, 1'b0, 1'b0, 1'b1);
        flag_vec("eq_5_5",  4'h5, 4'h5, 3'b111, 4'h1, 1'b0, 1'b0, 1'b0);

        // Exhaustive signed compare, streaming
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                drive(4'(i), 4'(j), 3'b110);
                cycle();
            end
        end
        bus.req_valid = 1'b0;
        cycle();

        // Back-pressure: third request waits for the first pop
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        drive(4'd1, 4'd2, 3'b000);
        cycle();
        drive(4'd3, 4'd4, 3'b001);
        cycle();
        drive(4'd5, 4'd6, 3'b101);
        check("bp_ready_full", 32'(bus.req_ready), 32'd0);
        cycle();
        drive(4'd9, 4'd9, 3'b011);
        cycle();
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_ready_on_pop", 32'(bus.req_ready), 32'd1);
        cycle();
        bus.req_valid = 1'b0;
        repeat (3) cycle();
        check("bp_drained", 32'(bus.rsp_valid), 32'd0);

        // Full FIFO with simultaneous push and pop
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        drive(4'd2, 4'd3, 3'b100);
        cycle();
        drive(4'd6, 4'd6, 3'b111);
        cycle();
        bus.rsp_ready = 1'b1;
        drive(4'd4, 4'hC, 3'b000);
        cycle();
        bus.rsp_ready = 1'b0;
        drive(4'd1, 4'd1, 3'b010);
        #1;
        check("full_still_full", 32'(bus.req_ready), 32'd0);
        check("full_valid",      32'(bus.rsp_valid), 32'd1);
        cycle();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (3) cycle();

        // Reset mid-stream with a request offered during reset
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        drive(4'd7, 4'd7, 3'b000);
        cycle();
        drive(4'd2, 4'd5, 3'b001);
        cycle();
        rst_n = 1'b0;
        drive(4'd8, 4'd8, 3'b000);
        cycle();
        rst_n = 1'b0;
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_count", 32'(req_count),     32'd0);
        flag_vec("post_rst", 4'd3, 4'd2, 3'b000, 4'd5, 1'b0, 1'b0, 1'b0);

        // Counter wrap: 2^CNT_W accepts from reset
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        for (int k = 0; k < (1 << CNT_W); k++) begin
            drive(4'($urandom), 4'($urandom), 3'($urandom));
            cycle();
        end
        bus.req_valid = 1'b0;
        check("count_wrap", 32'(req_count), 32'd0);
        cycle();

        // Randomized traffic with random back-pressure
        for (int k = 0; k < 800; k++) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            drive(4'($urandom), 4'($urandom), 3'($urandom));
            cycle();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (4) cycle();
        check("final_drained", 32'(bus.rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
